stm_segment_scheduler: RTL and testbench

- Sequencing controller for the STM datapath: decides which segment (0/1) and which sample index the `stm` block reads on every UPDATE tick from `time_cnt_generator`.
- Handles per-segment frequency division, cycle wrap, finite/infinite repeat counts and the segment-swap rule selected by the transition mode.
- Sits between the settings registers (`stm_settings_t`) and `stm`; drives its read segment/index and a stop flag.

---
 rtl/stm_segment_scheduler_pkg.sv | 47 ++++
 rtl/stm_segment_scheduler_if.sv | 36 +++
 rtl/stm_segment_scheduler_idx_counter.sv | 70 +++++++
 rtl/stm_segment_scheduler.sv | 138 +++++++++++++
 tb/tb_stm_segment_scheduler.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/stm_segment_scheduler_pkg.sv
// Shared constants and types for the STM segment scheduler: transition mode
// codes, segment count, the infinite-repeat marker and the FSM/request types.
package stm_segment_scheduler_pkg;

    localparam int          NUM_SEGMENT  = 2;
    localparam logic [31:0] REP_INFINITE = 32'hFFFF_FFFF;

    localparam logic [7:0] TRANSITION_MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0] TRANSITION_MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0] TRANSITION_MODE_GPIO      = 8'h02;
    localparam logic [7:0] TRANSITION_MODE_EXT       = 8'hF0;
    localparam logic [7:0] TRANSITION_MODE_IMMEDIATE = 8'hFF;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_EXT_RUN
    } state_t;

    typedef enum logic [2:0] {
        SW_SYNC_IDX,
        SW_SYS_TIME,
        SW_GPIO,
        SW_EXT,
        SW_IMMEDIATE
    } swap_rule_t;

    // A segment-change request captured on SET, held until the swap fires.
    typedef struct packed {
        logic        segment;
        logic [31:0] rep;
        logic [7:0]  mode;
        logic [63:0] value;
    } request_t;

    // Unknown mode codes fall back to an immediate swap.
    function automatic swap_rule_t decode_mode(input logic [7:0] mode);
        case (mode)
            TRANSITION_MODE_SYNC_IDX: return SW_SYNC_IDX;
            TRANSITION_MODE_SYS_TIME: return SW_SYS_TIME;
            TRANSITION_MODE_GPIO:     return SW_GPIO;
            TRANSITION_MODE_EXT:      return SW_EXT;
            default:                  return SW_IMMEDIATE;
        endcase
    endfunction

endpackage

// File: rtl/stm_segment_scheduler_if.sv
// Settings/control inputs and read-pointer outputs of the segment scheduler.
// master = settings side / consumer of the read pointer, slave = scheduler.
interface stm_segment_scheduler_if
    import stm_segment_scheduler_pkg::*;
#(
    parameter int IDX_W  = 13,
    parameter int GPIO_W = 4
);
    logic [63:0]                        SYS_TIME;
    logic                               UPDATE;
    logic                               SET;
    logic                               REQ_SEGMENT;
    logic [31:0]                        REP;
    logic [7:0]                         TRANSITION_MODE;
    logic [63:0]                        TRANSITION_VALUE;
    logic [NUM_SEGMENT-1:0][IDX_W-1:0]  CYCLE;
    logic [NUM_SEGMENT-1:0][31:0]       FREQ_DIV;
    logic [GPIO_W-1:0]                  GPIO_IN;
    logic                               SEGMENT;
    logic [IDX_W-1:0]                   IDX;
    logic                               STOP;
    logic                               SWITCHED;

    modport master (
        output SYS_TIME, UPDATE, SET, REQ_SEGMENT, REP, TRANSITION_MODE,
               TRANSITION_VALUE, CYCLE, FREQ_DIV, GPIO_IN,
        input  SEGMENT, IDX, STOP, SWITCHED
    );

    modport slave (
        input  SYS_TIME, UPDATE, SET, REQ_SEGMENT, REP, TRANSITION_MODE,
               TRANSITION_VALUE, CYCLE, FREQ_DIV, GPIO_IN,
        output SEGMENT, IDX, STOP, SWITCHED
    );

endinterface

// File: rtl/stm_segment_scheduler_idx_counter.sv
// Sample-index counter for the active segment: frequency division, cycle
// wrap, finite repeat accounting and the STOP hold. `wrap` flags the tick on
// which the segment reaches its last sample boundary (even if it then stops).
module stm_idx_counter
    import stm_segment_scheduler_pkg::*;
#(
    parameter int IDX_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [31:0]       load_rep,
    input  logic              advance,
    input  logic [IDX_W-1:0]  cycle,
    input  logic [31:0]       freq_div,
    output logic [IDX_W-1:0]  idx,
    output logic              stop,
    output logic              wrap
);

    logic [31:0] div_cnt;
    logic [31:0] rep_cnt;
    logic        step;
    logic        last_tick;
    logic        at_end;

    // >= rather than == so a shrunk FREQ_DIV/CYCLE cannot strand the counter
    // beyond the new limit; it simply completes at the next comparison.
    assign step      = advance & ~stop;
    assign last_tick = div_cnt >= (freq_div - 32'd1);
    assign at_end    = idx >= cycle;
    assign wrap      = step & last_tick & at_end;

    // Divider, index and repeat bookkeeping; a load restarts the segment.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // the pre-edge values; blocking here would create order-dependent races.
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
            rep_cnt <= REP_INFINITE;
            stop    <= 1'b0;
        end else if (load) begin
            div_cnt <= '0;
            idx     <= '0;
            rep_cnt <= load_rep;
            stop    <= 1'b0;
        end else if (step) begin
            if (last_tick) begin
                div_cnt <= '0;
                if (at_end) begin
                    if (rep_cnt == REP_INFINITE) begin
                        idx <= '0;
                    end else if (rep_cnt == 32'd0) begin
                        idx  <= cycle;
                        stop <= 1'b1;
                    end else begin
                        idx     <= '0;
                        rep_cnt <= rep_cnt - 32'd1;
                    end
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end else begin
                div_cnt <= div_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/stm_segment_scheduler.sv
// STM segment scheduler: holds the pending segment-change request, evaluates
// the transition rule each cycle and drives the read segment/index for `stm`.
module stm_segment_scheduler
    import stm_segment_scheduler_pkg::*;
#(
    parameter int IDX_W  = 13,
    parameter int GPIO_W = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    stm_segment_scheduler_if.slave  bus
);

    localparam int SEL_W = (GPIO_W > 1) ? $clog2(GPIO_W) : 1;

    state_t            state;
    state_t            state_next;
    request_t          pending;
    swap_rule_t        rule;
    logic              segment;
    logic              switched;
    logic              swap;
    logic              swap_segment;
    logic [31:0]       swap_rep;
    logic              sync_hit;
    logic              gpio_hit;
    logic [SEL_W-1:0]  gpio_sel;
    logic [GPIO_W-1:0] gpio_prev;
    logic [GPIO_W-1:0] gpio_edge;
    logic [GPIO_W-1:0] gpio_rise;
    logic [IDX_W-1:0]  idx;
    logic              stop;
    logic              wrap;

    assign rule      = decode_mode(pending.mode);
    assign gpio_rise = bus.GPIO_IN & ~gpio_prev;
    assign gpio_sel  = pending.value[SEL_W-1:0];
    assign gpio_hit  = gpio_edge[gpio_sel] | gpio_rise[gpio_sel];
    // A stopped segment never wraps again, so the next tick stands in for it.
    assign sync_hit  = wrap | (bus.UPDATE & stop);

    stm_idx_counter #(.IDX_W(IDX_W)) u_idx_counter (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (swap),
        .load_rep (swap_rep),
        .advance  (bus.UPDATE),
        .cycle    (bus.CYCLE[segment]),
        .freq_div (bus.FREQ_DIV[segment]),
        .idx      (idx),
        .stop     (stop),
        .wrap     (wrap)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_RUN;
        else        state <= state_next;
    end

    // Next state: a new SET always (re)enters WAIT, even when a swap for the
    // previous request fires in the same cycle.
    always_comb begin
        state_next = state;
        if (bus.SET) begin
            state_next = ST_WAIT;
        end else if (swap) begin
            state_next = (state == ST_EXT_RUN || rule == SW_EXT) ? ST_EXT_RUN : ST_RUN;
        end
    end

    // Swap decision and what the swap loads into the index counter.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        swap         = 1'b0;
        swap_segment = pending.segment;
        swap_rep     = pending.rep;
        case (state)
            ST_WAIT: begin
                case (rule)
                    SW_SYNC_IDX: swap = sync_hit;
                    SW_SYS_TIME: swap = bus.UPDATE & (bus.SYS_TIME >= pending.value);
                    SW_GPIO:     swap = bus.UPDATE & gpio_hit;
                    SW_EXT: begin
                        swap     = sync_hit;
                        swap_rep = REP_INFINITE;
                    end
                    default:     swap = 1'b1;
                endcase
            end
            ST_EXT_RUN: begin
                swap         = wrap;
                swap_segment = ~segment;
                swap_rep     = REP_INFINITE;
            end
            default: ;
        endcase
    end

    // Pending request capture; the last SET wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: the pending request is explicitly reset so a request issued
        // before a reset can never fire after it.
        if (!RST_N)       pending <= '{segment: 1'b0, rep: REP_INFINITE, mode: '0, value: '0};
        else if (bus.SET) pending <= '{segment: bus.REQ_SEGMENT, rep: bus.REP,
                                       mode: bus.TRANSITION_MODE, value: bus.TRANSITION_VALUE};
    end

    // Active segment and the one-cycle SWITCHED pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            segment  <= 1'b0;
            switched <= 1'b0;
        end else begin
            switched <= swap;
            if (swap) segment <= swap_segment;
        end
    end

    // GPIO rising edges are held until a new request or a swap consumes them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gpio_prev <= '0;
            gpio_edge <= '0;
        end else begin
            gpio_prev <= bus.GPIO_IN;
            if (bus.SET || swap) gpio_edge <= '0;
            else                 gpio_edge <= gpio_edge | gpio_rise;
        end
    end

    assign bus.SEGMENT  = segment;
    assign bus.IDX      = idx;
    assign bus.STOP     = stop;
    assign bus.SWITCHED = switched;

endmodule

// File: tb/tb_stm_segment_scheduler.sv
// Directed bench for stm_segment_scheduler. Stimulus pushes the expected
// read pointer for each UPDATE tick (or probe) into a scoreboard queue; a
// monitor pops and compares one cycle later, and on every reset assertion.
module tb_stm_segment_scheduler;
    import stm_segment_scheduler_pkg::*;

    localparam int IDX_W  = 13;
    localparam int GPIO_W = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    logic probe = 1'b0;

    typedef struct {
        logic             seg;
        logic [IDX_W-1:0] idx;
        logic             stop;
        logic             sw;
        string            tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Free-running clock.
    always #5 CLK = ~CLK;

    stm_segment_scheduler_if #(.IDX_W(IDX_W), .GPIO_W(GPIO_W)) bus ();

    stm_segment_scheduler #(.IDX_W(IDX_W), .GPIO_W(GPIO_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    task automatic expect_out(input logic s, input int i, input logic st, input logic sw,
                              input string tag);
        exp_t e;
        e.seg  = s;
        e.idx  = IDX_W'(i);
        e.stop = st;
        e.sw   = sw;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got seg=%0d idx=%0d stop=%0d sw=%0d, required nothing queued",
                     bus.SEGMENT, bus.IDX, bus.STOP, bus.SWITCHED);
            return;
        end
        e = sb.pop_front();
        if (bus.SEGMENT !== e.seg || bus.IDX !== e.idx || bus.STOP !== e.stop || bus.SWITCHED !== e.sw) begin
            n_err++;
            $display("FAIL %s: got seg=%0d idx=%0d stop=%0d sw=%0d, required seg=%0d idx=%0d stop=%0d sw=%0d",
                     e.tag, bus.SEGMENT, bus.IDX, bus.STOP, bus.SWITCHED, e.seg, e.idx, e.stop, e.sw);
        end
    endtask

    // Monitor: outputs registered on a tick/probe edge are compared at the next negedge.
    initial begin
        logic trig;
        forever begin
            @(posedge CLK);
            trig = bus.UPDATE | probe;
            @(negedge CLK);
            if (trig) compare_front();
        end
    end

    // Monitor: reset must clear the outputs without waiting for a clock edge.
    always @(negedge RST_N) begin
        #1;
        compare_front();
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input logic s, input int i, input logic st, input logic sw, input string tag);
        bus.UPDATE = 1'b1;
        expect_out(s, i, st, sw, tag);
        @(negedge CLK);
        bus.UPDATE = 1'b0;
    endtask

    task automatic probe_out(input logic s, input int i, input logic st, input logic sw, input string tag);
        probe = 1'b1;
        expect_out(s, i, st, sw, tag);
        @(negedge CLK);
        probe = 1'b0;
    endtask

    task automatic set_req(input logic seg, input logic [31:0] rep, input logic [7:0] mode,
                           input logic [63:0] val);
        bus.SET              = 1'b1;
        bus.REQ_SEGMENT      = seg;
        bus.REP              = rep;
        bus.TRANSITION_MODE  = mode;
        bus.TRANSITION_VALUE = val;
        @(negedge CLK);
        bus.SET = 1'b0;
    endtask

    task automatic gpio_pulse(input logic [GPIO_W-1:0] lines);
        bus.GPIO_IN = lines;
        @(negedge CLK);
        bus.GPIO_IN = '0;
    endtask

    // Directed stimulus.
    initial begin
        bus.SYS_TIME         = 64'd0;
        bus.UPDATE           = 1'b0;
        bus.SET              = 1'b0;
        bus.REQ_SEGMENT      = 1'b0;
        bus.REP              = REP_INFINITE;
        bus.TRANSITION_MODE  = TRANSITION_MODE_SYNC_IDX;
        bus.TRANSITION_VALUE = 64'd0;
        bus.CYCLE[0]         = 13'd15;
        bus.CYCLE[1]         = 13'd3;
        bus.FREQ_DIV[0]      = 32'd1;
        bus.FREQ_DIV[1]      = 32'd3;
        bus.GPIO_IN          = '0;

        // Power-on reset.
        #2;
        expect_out(1'b0, 0, 1'b0, 1'b0, "reset_async");
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        probe_out(1'b0, 0, 1'b0, 1'b0, "reset_state");

        // Seg0 free-running, CYCLE=15, FREQ_DIV=1, infinite repeat.
        for (int i = 1; i <= 40; i++) tick(1'b0, i % 16, 1'b0, 1'b0, "free_run");

        // SYNC_IDX to seg1 (CYCLE=3, FREQ_DIV=3, REP=0): swap at seg0 15->0.
        set_req(1'b1, 32'd0, TRANSITION_MODE_SYNC_IDX, 64'd0);
        for (int i = 9; i <= 15; i++) tick(1'b0, i, 1'b0, 1'b0, "sync_wait");
        tick(1'b1, 0, 1'b0, 1'b1, "sync_swap");
        for (int j = 1; j <= 12; j++) tick(1'b1, (j < 12) ? j / 3 : 3, j == 12, 1'b0, "seg1_div3");
        tick(1'b1, 3, 1'b1, 1'b0, "seg1_stopped_hold");

        // SYS_TIME threshold 1000 ahead.
        bus.SYS_TIME = 64'd5000;
        set_req(1'b0, REP_INFINITE, TRANSITION_MODE_SYS_TIME, 64'd6000);
        bus.SYS_TIME = 64'd5500;
        tick(1'b1, 3, 1'b1, 1'b0, "systime_early");
        bus.SYS_TIME = 64'd5999;
        tick(1'b1, 3, 1'b1, 1'b0, "systime_just_before");
        bus.SYS_TIME = 64'd6000;
        tick(1'b0, 0, 1'b0, 1'b1, "systime_swap");
        tick(1'b0, 1, 1'b0, 1'b0, "systime_after");

        // GPIO line 2; a pulse on line 1 must be ignored.
        bus.FREQ_DIV[1] = 32'd1;
        set_req(1'b1, REP_INFINITE, TRANSITION_MODE_GPIO, 64'd2);
        gpio_pulse(4'b0010);
        @(negedge CLK);
        tick(1'b0, 2, 1'b0, 1'b0, "gpio_other_line");
        gpio_pulse(4'b0100);
        repeat (2) @(negedge CLK);
        tick(1'b1, 0, 1'b0, 1'b1, "gpio_swap");

        // EXT: CYCLE0=3, CYCLE1=1; REP=0 must be ignored.
        bus.CYCLE[0] = 13'd3;
        bus.CYCLE[1] = 13'd1;
        set_req(1'b0, 32'd0, TRANSITION_MODE_EXT, 64'd0);
        tick(1'b1, 1, 1'b0, 1'b0, "ext_wait");
        tick(1'b0, 0, 1'b0, 1'b1, "ext_first_swap");
        for (int i = 1; i <= 3; i++) tick(1'b0, i, 1'b0, 1'b0, "ext_seg0");
        tick(1'b1, 0, 1'b0, 1'b1, "ext_to_seg1");
        tick(1'b1, 1, 1'b0, 1'b0, "ext_seg1");
        tick(1'b0, 0, 1'b0, 1'b1, "ext_to_seg0");
        for (int i = 1; i <= 3; i++) tick(1'b0, i, 1'b0, 1'b0, "ext_seg0_again");
        tick(1'b1, 0, 1'b0, 1'b1, "ext_to_seg1_again");
        tick(1'b1, 1, 1'b0, 1'b0, "ext_seg1_again");

        // IMMEDIATE exits EXT without an UPDATE; no further automatic swaps.
        set_req(1'b0, REP_INFINITE, TRANSITION_MODE_IMMEDIATE, 64'd0);
        probe_out(1'b0, 0, 1'b0, 1'b1, "immediate_swap");
        for (int i = 1; i <= 3; i++) tick(1'b0, i, 1'b0, 1'b0, "post_ext_run");
        tick(1'b0, 0, 1'b0, 1'b0, "post_ext_wrap_stays");

        // Reset while WAITing on a far-future SYS_TIME request.
        set_req(1'b1, REP_INFINITE, TRANSITION_MODE_IMMEDIATE, 64'd0);
        probe_out(1'b1, 0, 1'b0, 1'b1, "immediate_to_seg1");
        tick(1'b1, 1, 1'b0, 1'b0, "seg1_run");
        set_req(1'b0, REP_INFINITE, TRANSITION_MODE_SYS_TIME, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(1'b1, 0, 1'b0, 1'b0, "wait_seg1_wrap");
        tick(1'b1, 1, 1'b0, 1'b0, "wait_seg1_run");
        #2;
        expect_out(1'b0, 0, 1'b0, 1'b0, "reset_mid_wait");
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        bus.SYS_TIME = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(1'b0, 1, 1'b0, 1'b0, "after_reset_no_pending");

        repeat (3) @(negedge CLK);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
